// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolver: registered PC redirect, pipeline flushes and perf counters.
// Optional 2-bit branch history table enabled by defining BRANCH_PRED_EN.
module branch_resolve #(
   parameter int BHT_DEPTH = 16
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_is_jal,
   input  logic        ex_is_jalr,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1,
   input  logic        alu_f,
   input  logic        ex_pred_taken,
   input  logic        stall,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        flush_ex_mem,
   output logic [31:0] br_cnt,
   output logic [31:0] mis_cnt
);

   typedef enum logic {
      IDLE,
      REDIRECT
   } state_t;

   state_t      state;
   logic        flush;
   logic        resolve;
   logic        is_cond;
   logic        pred_eff;
   logic        need_redirect;
   logic [31:0] next_pc;
   logic [31:0] br_target;
   logic [31:0] jalr_target;
   logic [31:0] fall_pc;

   assign resolve     = ex_valid & ~stall & (state == IDLE);
   assign is_cond     = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
   assign br_target   = ex_pc + ex_imm;
   assign jalr_target = (ex_rs1 + ex_imm) & ~32'h1;
   assign fall_pc     = ex_pc + 32'd4;

   always_comb begin
      need_redirect = 1'b0;
      next_pc       = br_target;
      if (ex_is_jal) begin
         need_redirect = 1'b1;
      end else if (ex_is_jalr) begin
         need_redirect = 1'b1;
         next_pc       = jalr_target;
      end else if (ex_is_branch) begin
         if (alu_f && !pred_eff) begin
            need_redirect = 1'b1;
         end else if (!alu_f && pred_eff) begin
            need_redirect = 1'b1;
            next_pc       = fall_pc;
         end
      end
   end

   // NOTE: all state below updates with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state          <= IDLE;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'h0;
         flush          <= 1'b0;
         br_cnt         <= 32'h0;
         mis_cnt        <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (resolve) begin
                  if (is_cond) begin
                     br_cnt <= br_cnt + 32'd1;
                  end
                  if (need_redirect) begin
                     state          <= REDIRECT;
                     redirect_valid <= 1'b1;
                     redirect_pc    <= next_pc;
                     flush          <= 1'b1;
                     if (is_cond) begin
                        mis_cnt <= mis_cnt + 32'd1;
                     end
                  end
               end
            end
            REDIRECT: begin
               // The EX instruction is wrong-path here; hold outputs until the stall releases.
               if (!stall) begin
                  state          <= IDLE;
                  redirect_valid <= 1'b0;
                  redirect_pc    <= 32'h0;
                  flush          <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign flush_if_id  = flush;
   assign flush_id_ex  = flush;
   assign flush_ex_mem = flush;

`ifdef BRANCH_PRED_EN
   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]       bht [BHT_DEPTH];
   logic [IDX_W-1:0] ex_idx;
   logic [IDX_W-1:0] if_idx;

   assign ex_idx        = ex_pc[IDX_W+1:2];
   assign if_idx        = if_pc[IDX_W+1:2];
   assign if_pred_taken = bht[if_idx][1];
   assign pred_eff      = ex_pred_taken;

   // NOTE: the table is small and must come up weakly not-taken, so every entry is reset explicitly.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (resolve && is_cond) begin
         if (alu_f && bht[ex_idx] != 2'b11) begin
            bht[ex_idx] <= bht[ex_idx] + 2'd1;
         end else if (!alu_f && bht[ex_idx] != 2'b00) begin
            bht[ex_idx] <= bht[ex_idx] - 2'd1;
         end
      end
   end
`else
   logic unused_pred;

   assign unused_pred   = ^{if_pc, ex_pred_taken};
   assign if_pred_taken = 1'b0;
   assign pred_eff      = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: stimulus pushes expected redirect PCs, a monitor pops them.
// Predictor expectations switch on BRANCH_PRED_EN.
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        cpu_rst;
   logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [31:0] ex_pc, ex_imm, ex_rs1;
   logic        alu_f, ex_pred_taken, stall;
   logic [31:0] if_pc;
   logic        if_pred_taken, redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_if_id, flush_id_ex, flush_ex_mem;
   logic [31:0] br_cnt, mis_cnt;

   int          checks = 0;
   int          errors = 0;
   int          exp_br = 0;
   int          exp_mis = 0;
   bit          done = 1'b0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   branch_resolve #(.BHT_DEPTH(16)) dut (
      .cpu_clk        (clk),
      .cpu_rst        (cpu_rst),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_is_jal      (ex_is_jal),
      .ex_is_jalr     (ex_is_jalr),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .ex_rs1         (ex_rs1),
      .alu_f          (alu_f),
      .ex_pred_taken  (ex_pred_taken),
      .stall          (stall),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .flush_ex_mem   (flush_ex_mem),
      .br_cnt         (br_cnt),
      .mis_cnt        (mis_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_ex();
      ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
      alu_f = 1'b0; ex_pred_taken = 1'b0;
   endtask

   task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic f, input logic pred);
      ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
      ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; alu_f = f; ex_pred_taken = pred;
   endtask

   // One instruction presented for one cycle, with its hand-computed outcome.
   task automatic vec(input string name, input logic v, input logic br, input logic jal,
                      input logic jalr, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic f, input logic pred,
                      input logic exp_redir, input logic [31:0] exp_pc,
                      input int dbr, input int dmis);
      @(posedge clk); #1;
      drive(v, br, jal, jalr, pc, imm, rs1, f, pred);
      if (exp_redir) exp_q.push_back(exp_pc);
      exp_br  += dbr;
      exp_mis += dmis;
      @(posedge clk); #1;
      clear_ex();
      @(negedge clk);
      check({name, "_br_cnt"}, br_cnt, exp_br);
      check({name, "_mis_cnt"}, mis_cnt, exp_mis);
   endtask

   // Monitor: every cycle with redirect_valid high consumes one expected PC.
   initial begin
      forever begin
         @(negedge clk);
         if (done) break;
         if (!cpu_rst) begin
            if (redirect_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_redirect", redirect_pc, 32'hxxxx_xxxx);
               end else begin
                  check("redirect_pc", redirect_pc, exp_q.pop_front());
                  check("flush_on_redirect", {29'h0, flush_if_id, flush_id_ex, flush_ex_mem}, 32'h7);
               end
            end else begin
               check("flush_idle", {29'h0, flush_if_id, flush_id_ex, flush_ex_mem}, 32'h0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      cpu_rst = 1'b1; stall = 1'b0; if_pc = 32'h40;
      ex_pc = 32'h0; ex_imm = 32'h0; ex_rs1 = 32'h0;
      clear_ex();
      repeat (2) @(posedge clk);
      #1;
      check("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
      check("rst_redirect_pc", redirect_pc, 32'h0);
      check("rst_flush", {29'h0, flush_if_id, flush_id_ex, flush_ex_mem}, 32'h0);
      check("rst_br_cnt", br_cnt, 32'h0);
      check("rst_mis_cnt", mis_cnt, 32'h0);
      check("rst_if_pred", {31'h0, if_pred_taken}, 32'h0);
      cpu_rst = 1'b0;

      //   name         v  br jal jalr pc            imm           rs1           f  p  redir pc           dbr dmis
      vec("beq_taken",  1, 1, 0, 0, 32'h100,      32'h20,       32'h0,        1, 0, 1, 32'h120,      1, 1);
      vec("jalr_align", 1, 0, 0, 1, 32'h104,      32'h4,        32'h2003,     0, 0, 1, 32'h2006,     0, 0);
      vec("jal_back",   1, 0, 1, 0, 32'h300,      32'hFFFF_FFF8, 32'h0,       0, 1, 1, 32'h2F8,      0, 0);
      vec("prio_jal",   1, 1, 1, 1, 32'h400,      32'h10,       32'h1000,     1, 0, 1, 32'h410,      0, 0);
      vec("prio_jalr",  1, 1, 0, 1, 32'h400,      32'h11,       32'h1000,     1, 0, 1, 32'h1010,     0, 0);
      vec("nt_nopred",  1, 1, 0, 0, 32'h200,      32'h40,       32'h0,        0, 0, 0, 32'h0,        1, 0);
`ifdef BRANCH_PRED_EN
      vec("nt_pred",    1, 1, 0, 0, 32'h200,      32'h40,       32'h0,        0, 1, 1, 32'h204,      1, 1);
      vec("tk_pred",    1, 1, 0, 0, 32'h180,      32'h40,       32'h0,        1, 1, 0, 32'h0,        1, 0);
`else
      vec("nt_pred",    1, 1, 0, 0, 32'h200,      32'h40,       32'h0,        0, 1, 0, 32'h0,        1, 0);
      vec("tk_pred",    1, 1, 0, 0, 32'h180,      32'h40,       32'h0,        1, 1, 1, 32'h1C0,      1, 1);
`endif
      vec("wrap",       1, 1, 0, 0, 32'hFFFF_FFF0, 32'h20,      32'h0,        1, 0, 1, 32'h10,       1, 1);
      vec("invalid",    0, 1, 1, 1, 32'h500,      32'h20,       32'h0,        1, 0, 0, 32'h0,        0, 0);

      // Shadow: second taken branch right behind the first is wrong-path.
      @(posedge clk); #1;
      drive(1, 1, 0, 0, 32'h500, 32'h10, 32'h0, 1, 0);
      exp_q.push_back(32'h510);
      exp_br++; exp_mis++;
      @(posedge clk); #1;
      drive(1, 1, 0, 0, 32'h600, 32'h40, 32'h0, 1, 0);
      @(posedge clk); #1;
      clear_ex();
      @(negedge clk);
      check("shadow_br_cnt", br_cnt, exp_br);
      check("shadow_mis_cnt", mis_cnt, exp_mis);

      // Stall hold: 3 stall cycles from the redirect cycle keep it up for 4 cycles.
      @(posedge clk); #1;
      drive(1, 1, 0, 0, 32'h700, 32'h100, 32'h0, 1, 0);
      repeat (4) exp_q.push_back(32'h800);
      exp_br++; exp_mis++;
      @(posedge clk); #1;
      clear_ex();
      stall = 1'b1;
      repeat (3) @(posedge clk);
      #1 stall = 1'b0;
      @(posedge clk); #1;
      check("stall_release", {31'h0, redirect_valid}, 32'h0);

      // Stall in IDLE blocks resolution entirely.
      drive(1, 1, 0, 0, 32'h880, 32'h100, 32'h0, 1, 0);
      stall = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clear_ex();
      stall = 1'b0;
      @(negedge clk);
      check("idle_stall_br_cnt", br_cnt, exp_br);

      // Reset while in REDIRECT drops the pending redirect and clears counters.
      @(posedge clk); #1;
      drive(1, 1, 0, 0, 32'h900, 32'h8, 32'h0, 1, 0);
      exp_q.push_back(32'h908);
      @(posedge clk); #1;
      clear_ex();
      stall = 1'b1;
      @(negedge clk); #1;
      cpu_rst = 1'b1;
      @(posedge clk); #1;
      cpu_rst = 1'b0;
      stall = 1'b0;
      exp_br = 0; exp_mis = 0;
      @(negedge clk);
      check("rst_redir_valid", {31'h0, redirect_valid}, 32'h0);
      check("rst_redir_pc", redirect_pc, 32'h0);
      check("rst_redir_br_cnt", br_cnt, 32'h0);
      check("rst_redir_mis_cnt", mis_cnt, 32'h0);
      check("bht_init", {31'h0, if_pred_taken}, 32'h0);

      // Predictor training at pc 0x40.
      vec("bht_first",  1, 1, 0, 0, 32'h40, 32'h80, 32'h0, 1, 0, 1, 32'hC0, 1, 1);
`ifdef BRANCH_PRED_EN
      check("bht_trained", {31'h0, if_pred_taken}, 32'h1);
      vec("bht_second", 1, 1, 0, 0, 32'h40, 32'h80, 32'h0, 1, 1, 0, 32'h0,  1, 0);
`else
      check("bht_trained", {31'h0, if_pred_taken}, 32'h0);
      vec("bht_second", 1, 1, 0, 0, 32'h40, 32'h80, 32'h0, 1, 1, 1, 32'hC0, 1, 1);
`endif
      check("final_br_cnt", br_cnt, 32'd2);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("queue_drain", exp_q.size(), 32'h0);
      done = 1'b1;
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
